// File: rtl/apb_master_if.sv
// apb_master_if: command/response handshake plus APB bus signals for apb_master.
// The master modport is the apb_master view; the slave modport is the
// requester + APB slave side (driven by the surrounding system or a bench).
interface apb_master_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   // command side
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [1:0]            req_id;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   // response side
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   // APB side
   logic [3:0]            sel;
   logic                  enable;
   logic                  write;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;

   modport master (
      input  req_valid, req_write, req_id, req_addr, req_wdata, rdata, ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             sel, enable, write, addr, wdata
   );

   modport slave (
      output req_valid, req_write, req_id, req_addr, req_wdata, rdata, ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             sel, enable, write, addr, wdata
   );
endinterface

// File: rtl/apb_master.sv
// apb_master: accepts one command at a time, runs it as an APB SETUP/ACCESS
// transfer to one of four slaves, and reports completion (or a wait-state
// timeout abort) with a single-cycle response pulse. All outputs are flops.
module apb_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16   // legal range 1..255
) (
   input logic          clk,
   input logic          rst,
   apb_master_if.master bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   // Wait count at which one more not-ready cycle means abort.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]            state_q,     state_d;
   logic                  req_ready_q, req_ready_d;
   logic [3:0]            sel_q,       sel_d;
   logic                  enable_q,    enable_d;
   logic                  write_q,     write_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q,   rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [7:0]            wait_cnt_q,  wait_cnt_d;

   // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
   always_comb begin
      // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      req_ready_d = req_ready_q;
      sel_d       = sel_q;
      enable_d    = enable_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;          // response is a single-cycle pulse
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      wait_cnt_d  = wait_cnt_q;

      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (bus.req_valid && req_ready_q) begin
               write_d     = bus.req_write;
               addr_d      = bus.req_addr;
               wdata_d     = bus.req_wdata;
               sel_d       = 4'b0001 << bus.req_id;
               req_ready_d = 1'b0;
               state_d     = ST_SETUP;
            end
         end

         ST_SETUP: begin
            enable_d   = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = ST_ACCESS;
         end

         ST_ACCESS: begin
            if (bus.ready) begin
               rsp_rdata_d = write_q ? '0 : bus.rdata;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               sel_d       = 4'b0000;
               enable_d    = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               // slave held off too long: abort with an error response
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               sel_d       = 4'b0000;
               enable_d    = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         default: begin
            sel_d       = 4'b0000;
            enable_d    = 1'b0;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State registers; synchronous reset overrides any transfer activity.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b0;
         sel_q       <= 4'b0000;
         enable_q    <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         wait_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         sel_q       <= sel_d;
         enable_q    <= enable_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.sel       = sel_q;
   assign bus.enable    = enable_q;
   assign bus.write     = write_q;
   assign bus.addr      = addr_q;
   assign bus.wdata     = wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed + randomized transfers against a transaction-level
// model; expectations are queued at acceptance and checked by a monitor.
module tb_apb_master;

   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

   apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic          wr;
      logic [1:0]    id;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic          err;
      int            done_cyc;
      int            en_cycles;
   } exp_t;

   exp_t          exp_q[$];
   int            n_cmp     = 0;
   int            n_bad     = 0;
   int            cyc       = 0;
   int            cur_w     = 0;
   logic [DW-1:0] cur_rdata = '0;
   logic          hold      = 1'b0;
   int            last_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Transaction-level model: W wait states, abort once W reaches TIMEOUT.
   function automatic exp_t model(input logic wr, input logic [1:0] id,
                                  input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                  input int w, input logic [DW-1:0] rd, input int n);
      exp_t e;
      e.wr        = wr;
      e.id        = id;
      e.addr      = a;
      e.wdata     = wd;
      e.err       = (w >= TMO);
      e.rdata     = (e.err || wr) ? '0 : rd;
      e.done_cyc  = e.err ? n + 1 + TMO : n + 2 + w;
      e.en_cycles = e.err ? TMO : w + 1;
      return e;
   endfunction

   task automatic scramble();
      bus_if.req_write = 1'($urandom);
      bus_if.req_id    = 2'($urandom);
      bus_if.req_addr  = AW'($urandom);
      bus_if.req_wdata = DW'($urandom);
   endtask

   // Present one command; garbage is shown while req_ready is low.
   task automatic issue(input logic wr, input logic [1:0] id, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int w, input logic [DW-1:0] rd,
                        input logic hold_after, input logic chk_b2b);
      exp_t e;
      bit   done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (bus_if.req_ready === 1'b1) begin
            bus_if.req_write = wr;
            bus_if.req_id    = id;
            bus_if.req_addr  = a;
            bus_if.req_wdata = wd;
            bus_if.req_valid = 1'b1;
            cur_w            = w;
            cur_rdata        = rd;
            if (chk_b2b) check("b2b_accept_cycle", 64'(cyc + 1), 64'(last_done + 1));
            e = model(wr, id, a, wd, w, rd, cyc + 1);
            exp_q.push_back(e);
            last_done = e.done_cyc;
            @(posedge clk);
            #1;
            hold             = hold_after;
            bus_if.req_valid = hold_after;
            scramble();
            done = 1'b1;
         end else begin
            bus_if.req_valid = hold;
            scramble();
         end
      end
      if (!done) check("accept_timeout", 64'(bus_if.req_ready), 64'(1));
   endtask

   // APB slave: ready after cur_w not-ready ACCESS cycles; random noise elsewhere.
   int acc_cnt = 0;
   always @(negedge clk) begin
      if (bus_if.enable === 1'b1) begin
         bus_if.ready = (acc_cnt == cur_w);
         bus_if.rdata = (acc_cnt == cur_w) ? cur_rdata : DW'($urandom);
         acc_cnt++;
      end else begin
         acc_cnt      = 0;
         bus_if.ready = 1'($urandom);
         bus_if.rdata = DW'($urandom);
      end
   end

   // Monitor: checks bus shape during a transfer and pops on each response.
   int   en_cnt   = 0;
   int   bus_bad  = 0;
   bit   seen_sel = 1'b0;
   exp_t m;
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         exp_q.delete();
         en_cnt   = 0;
         bus_bad  = 0;
         seen_sel = 1'b0;
      end else begin
         if (bus_if.sel !== 4'b0000) begin
            if (exp_q.size() == 0) begin
               bus_bad++;
            end else begin
               m = exp_q[0];
               if (bus_if.sel !== (4'b0001 << m.id) || bus_if.write !== m.wr ||
                   bus_if.addr !== m.addr || bus_if.wdata !== m.wdata) bus_bad++;
               if (!seen_sel) begin
                  if (bus_if.enable !== 1'b0) bus_bad++;
                  seen_sel = 1'b1;
               end else if (bus_if.enable !== 1'b1) begin
                  bus_bad++;
               end
               if (bus_if.enable === 1'b1) en_cnt++;
            end
         end else if (bus_if.enable !== 1'b0) begin
            bus_bad++;
         end

         if (bus_if.rsp_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 64'(bus_if.rsp_valid), 64'(0));
            end else begin
               m = exp_q.pop_front();
               check("rsp_err",      64'(bus_if.rsp_err),   64'(m.err));
               check("rsp_rdata",    64'(bus_if.rsp_rdata), 64'(m.rdata));
               check("rsp_cycle",    64'(cyc),              64'(m.done_cyc));
               check("enable_count", 64'(en_cnt),           64'(m.en_cycles));
               check("sel_at_rsp",   64'(bus_if.sel),       64'(0));
               check("bus_shape",    64'(bus_bad),          64'(0));
            end
            en_cnt   = 0;
            bus_bad  = 0;
            seen_sel = 1'b0;
         end
      end
   end

   // Reset in the 2nd ACCESS cycle of a 3-wait-state write.
   task automatic reset_mid();
      int k = 0;
      issue(1'b1, 2'd1, 8'h3C, 32'hDEADBEEF, 3, 32'h0, 1'b0, 1'b0);
      for (int t = 0; t < 20 && k < 2; t++) begin
         @(negedge clk);
         if (bus_if.enable === 1'b1) k++;
      end
      check("mid_reset_reached_access", 64'(k), 64'(2));
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_sel",    64'(bus_if.sel),    64'(0));
      check("mid_rst_enable", 64'(bus_if.enable), 64'(0));
      check("mid_rst_write",  64'(bus_if.write),  64'(0));
      check("mid_rst_addr",   64'(bus_if.addr),   64'(0));
      check("mid_rst_wdata",  64'(bus_if.wdata),  64'(0));
      for (int t = 0; t < 3; t++) begin
         check("mid_rst_req_ready", 64'(bus_if.req_ready), 64'(0));
         check("mid_rst_rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
         @(negedge clk);
      end
      rst = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      int            w;
      logic          wr;
      logic          hb;
      rst              = 1'b1;
      hold             = 1'b0;
      bus_if.req_valid = 1'b0;
      scramble();
      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(bus_if.req_ready), 64'(0));
      check("rst_sel",       64'(bus_if.sel),       64'(0));
      check("rst_enable",    64'(bus_if.enable),    64'(0));
      check("rst_write",     64'(bus_if.write),     64'(0));
      check("rst_addr",      64'(bus_if.addr),      64'(0));
      check("rst_wdata",     64'(bus_if.wdata),     64'(0));
      check("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
      check("rst_rsp_err",   64'(bus_if.rsp_err),   64'(0));
      check("rst_rsp_rdata", 64'(bus_if.rsp_rdata), 64'(0));
      rst = 1'b0;

      // zero-wait write, five-wait read, timeout read, last-chance read
      issue(1'b1, 2'd1, 8'h10, 32'hA5A5A5A5, 0,       32'h0,        1'b0, 1'b0);
      issue(1'b0, 2'd2, 8'h20, 32'h0,        5,       32'h12345678, 1'b0, 1'b0);
      issue(1'b0, 2'd0, 8'h44, 32'h0,        255,     32'hCAFEF00D, 1'b0, 1'b0);
      issue(1'b0, 2'd3, 8'h48, 32'h0,        TMO - 1, 32'h0BADC0DE, 1'b0, 1'b0);
      issue(1'b1, 2'd2, 8'h4C, 32'h5555AAAA, TMO,     32'h0,        1'b0, 1'b0);

      reset_mid();

      // back-to-back with req_valid held high
      issue(1'b1, 2'd3, 8'h30, 32'h0F0F0F0F, 2, 32'h0,        1'b1, 1'b0);
      issue(1'b0, 2'd0, 8'h34, 32'h0,        1, 32'h87654321, 1'b0, 1'b1);

      // wait-state sweep, both directions
      issue(1'b1, 2'd1, 8'h50, 32'h11111111, 1, 32'h0,        1'b0, 1'b0);
      issue(1'b1, 2'd2, 8'h54, 32'h22222222, 3, 32'h0,        1'b0, 1'b0);
      issue(1'b0, 2'd1, 8'h58, 32'h0,        1, 32'h33333333, 1'b0, 1'b0);
      issue(1'b0, 2'd2, 8'h5C, 32'h0,        3, 32'h44444444, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0:       w = TMO + $urandom_range(0, 8);
            1:       w = TMO - 1;
            default: w = $urandom_range(0, 6);
         endcase
         wr = 1'($urandom);
         hb = ($urandom_range(0, 2) == 0);
         issue(wr, 2'($urandom), AW'($urandom), DW'($urandom), w, DW'($urandom),
               hb, hold);
         if (!hb) repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // drain: every queued transfer must respond
      bus_if.req_valid = 1'b0;
      hold             = 1'b0;
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
      check("drain_outstanding", 64'(exp_q.size()), 64'(0));
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
